fp32_to_fp16_arbiter: RTL and testbench

- Shares one fp32_to_fp16 converter instance among NUM_REQ independent requesters.
- Round-robin arbiter selects one request per cycle into a 2-stage registered pipeline.
- Returns the fp16 result tagged with the requester index on a single valid/ready output stream.
- Sits between vector/accumulator units producing fp32 and fp16 storage/writeback paths.

---
 rtl/fp32_to_fp16_arbiter.sv | 151 +++++++++++++++
 tb/tb_fp32_to_fp16_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_fp16_arbiter.sv
// Round-robin sharing of one fp32->fp16 truncating converter among NUM_REQ requesters.
// Two registered stages (S1 operand, S2 result); results leave in acceptance order.
module fp32_to_fp16_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  output logic [15:0]             out_data,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready,
  output logic                    busy
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // req_ready may depend on req_valid; out_valid never depends on out_ready; a
  // stalled result (out_valid & ~out_ready) keeps out_data/out_id bit-stable.

  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_data_q,  s1_data_d;
  logic [ID_W-1:0] s1_id_q,    s1_id_d;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     out_data_q,  out_data_d;
  logic [ID_W-1:0] out_id_q,    out_id_d;
  logic [ID_W-1:0] rr_ptr_q,    rr_ptr_d;

  logic            s2_adv;
  logic            s1_free;
  logic            found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W:0]   idx;
  logic            accept;
  logic [31:0]     sel_data;
  logic [15:0]     conv_data;

  function automatic logic [15:0] fp32_to_fp16(input logic [31:0] f);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [23:0] sig;
    logic [4:0]  sh;
    logic [15:0] res;
    s   = f[31];
    e   = f[30:23];
    m   = f[22:0];
    sig = {1'b1, m};
    sh  = '0;
    res = {s, 15'h0000};
    if (e == 8'hff) begin
      res = (m != 23'd0) ? {s, 5'h1f, 10'h200} : {s, 5'h1f, 10'h000};
    end else if (e >= 8'd143) begin
      res = {s, 5'h1f, 10'h000};
    end else if (e >= 8'd113) begin
      res = {s, 5'(e - 8'd112), m[22:13]};
    end else if (e >= 8'd103) begin
      // fp16 denormal: hidden-one significand shifted down, low bits dropped.
      sh  = 5'(8'd126 - e);
      res = {s, 5'h00, 10'(sig >> sh)};
    end
    return res;
  endfunction

  assign s2_adv  = s1_valid_q & (~out_valid_q | out_ready);
  assign s1_free = ~s1_valid_q | s2_adv;

  // First set req_valid bit at or after rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) sel_data = req_data[32*i +: 32];
    end
  end

  // Gated by rst_n so no grant is offered while reset is held.
  always_comb begin
    accept    = found & s1_free & rst_n;
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  assign conv_data = fp32_to_fp16(s1_data_q);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_id_d     = s1_id_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = sel_data;
      s1_id_d    = grant_id;
      rr_ptr_d   = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s2_adv) begin
      out_valid_d = 1'b1;
      out_data_d  = conv_data;
      out_id_d    = s1_id_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_id_q     <= s1_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_fp32_to_fp16_arbiter.sv
// Bench for fp32_to_fp16_arbiter: scenario tasks plus an acceptance-ordered scoreboard.
module tb_fp32_to_fp16_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_valid;
  logic [15:0]           out_data;
  logic [ID_W-1:0]       out_id;
  logic                  out_ready;
  logic                  busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  fp32_to_fp16_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_ready(out_ready), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference conversion written from the real-number view of the value.
  function automatic logic [15:0] ref_cvt(input logic [31:0] f);
    int          ue;
    logic [23:0] mm;
    logic [15:0] r;
    ue = int'(f[30:23]) - 127;
    mm = {1'b1, f[22:0]};
    if (f[30:23] == 8'hff) r = (f[22:0] != 0) ? {f[31], 15'h7e00} : {f[31], 15'h7c00};
    else if (f[30:23] == 8'h00) r = {f[31], 15'h0000};
    else if (ue > 15) r = {f[31], 15'h7c00};
    else if (ue >= -14) r = {f[31], 5'(ue + 15), f[22:13]};
    else if (ue >= -24) begin mm = mm >> (-ue - 1); r = {f[31], 5'h00, mm[9:0]}; end
    else r = {f[31], 15'h0000};
    return r;
  endfunction

  // scoreboard: push on accept, pop/compare on output transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_extra: got id=%0d data=%h, required no output", out_id, out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({out_id, out_data} !== mon_exp)
            $display("FAIL scoreboard_result: got id=%0d data=%h, required id=%0d data=%h",
                     out_id, out_data, mon_exp[W-1:16], mon_exp[15:0]);
          else pass_cnt++;
        end
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && req_ready[i]) exp_q.push_back({ID_W'(i), ref_cvt(req_data[32*i +: 32])});
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = $urandom;
  endtask

  task automatic apply_reset();
    #1 rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = '0; out_ready = 1'b1; randomize_data();
    #2 rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
    chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b required 0000", req_ready); else pass_cnt++;
    chk_cnt++; if ({out_id, out_data} !== 18'h0) $display("FAIL reset_out_regs: got id=%0d data=%h required 0/0000", out_id, out_data); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 req_valid = '0; rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if ({busy, out_valid, req_ready} !== 6'b0) $display("FAIL reset_idle: got busy=%b ov=%b rr=%b required all 0", busy, out_valid, req_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    next_cycle();
    req_data[63:32] = 32'h3F80_0000; req_valid = 4'b0010; out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL single_ready: got %b required 0010", req_ready); else pass_cnt++;
    next_cycle(); req_valid = '0;
    @(negedge clk);
    chk_cnt++; if ({out_valid, busy, req_ready} !== 6'b010000) $display("FAIL single_s1: got ov=%b busy=%b rr=%b required 0/1/0000", out_valid, busy, req_ready); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    chk_cnt++; if ({out_valid, out_id, out_data} !== {1'b1, 2'd1, 16'h3C00}) $display("FAIL single_out: got v=%b id=%0d data=%h required 1/1/3c00", out_valid, out_id, out_data); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    chk_cnt++; if ({out_valid, busy} !== 2'b00) $display("FAIL single_idle: got ov=%b busy=%b required 0/0", out_valid, busy); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    next_cycle();
    randomize_data(); out_ready = 1'b1; req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_g = 4'b0001 << (k % 4);
      chk_cnt++; if (req_ready !== exp_g) $display("FAIL rr_grant_%0d: got %b required %b", k, req_ready, exp_g); else pass_cnt++;
      if (k >= 2) begin
        chk_cnt++; if ({out_valid, out_id} !== {1'b1, 2'((k - 2) % 4)}) $display("FAIL rr_out_%0d: got v=%b id=%0d required 1/%0d", k, out_valid, out_id, (k - 2) % 4); else pass_cnt++;
      end
      next_cycle();
      req_data[32*(k % 4) +: 32] = $urandom;
      if (k == 7) req_valid = '0;
    end
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      chk_cnt++; if ({out_valid, out_id} !== {1'b1, 2'(k % 4)}) $display("FAIL rr_drain_%0d: got v=%b id=%0d required 1/%0d", k, out_valid, out_id, k % 4); else pass_cnt++;
      next_cycle();
    end
    @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0 || exp_q.size() != 0) $display("FAIL rr_empty: got ov=%b pending=%0d required 0/0", out_valid, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    next_cycle();
    randomize_data(); d0 = req_data[31:0]; out_ready = 1'b0; req_valid = 4'b0111;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL bp_grant0: got %b required 0001", req_ready); else pass_cnt++;
    next_cycle(); req_valid = 4'b0110;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL bp_grant1: got %b required 0010", req_ready); else pass_cnt++;
    next_cycle(); req_valid = 4'b0100;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk_cnt++;
      if ({req_ready, out_valid, out_id, out_data} !== {4'b0000, 1'b1, 2'd0, ref_cvt(d0)})
        $display("FAIL bp_stall_%0d: got rr=%b v=%b id=%0d data=%h required 0000/1/0/%h", s, req_ready, out_valid, out_id, out_data, ref_cvt(d0));
      else pass_cnt++;
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if ({req_ready, out_valid, out_id} !== {4'b0100, 1'b1, 2'd0}) $display("FAIL bp_release: got rr=%b v=%b id=%0d required 0100/1/0", req_ready, out_valid, out_id); else pass_cnt++;
    next_cycle(); req_valid = '0;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      chk_cnt++; if ({out_valid, out_id} !== {1'b1, 2'(k)}) $display("FAIL bp_order_%0d: got v=%b id=%0d required 1/%0d", k, out_valid, out_id, k); else pass_cnt++;
      next_cycle();
    end
    @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b required 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_special();
    logic [31:0] sv_in [6];
    logic [15:0] sv_out [6];
    int t;
    sv_in[0] = 32'h7F80_0000; sv_out[0] = 16'h7C00;
    sv_in[1] = 32'hFFC0_0000; sv_out[1] = 16'hFE00;
    sv_in[2] = 32'h4780_0000; sv_out[2] = 16'h7C00;
    sv_in[3] = 32'h3380_0000; sv_out[3] = 16'h0001;
    sv_in[4] = 32'h8000_0000; sv_out[4] = 16'h8000;
    sv_in[5] = 32'h0040_0000; sv_out[5] = 16'h0000;
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      next_cycle();
      req_data[127:96] = sv_in[v]; req_valid = 4'b1000;
      @(negedge clk);
      chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL special_ready_%0d: got %b required 1000", v, req_ready); else pass_cnt++;
      next_cycle(); req_valid = '0;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 4) begin @(negedge clk); t++; end
      chk_cnt++;
      if ({out_valid, out_id, out_data} !== {1'b1, 2'd3, sv_out[v]})
        $display("FAIL special_%h: got v=%b id=%0d data=%h required 1/3/%h", sv_in[v], out_valid, out_id, out_data, sv_out[v]);
      else pass_cnt++;
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    next_cycle();
    randomize_data(); out_ready = 1'b0; req_valid = 4'b0110;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0010) $display("FAIL rm_grant1: got %b required 0010", req_ready); else pass_cnt++;
    next_cycle(); req_valid = 4'b0100;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0100) $display("FAIL rm_grant2: got %b required 0100", req_ready); else pass_cnt++;
    next_cycle(); req_valid = 4'b0110;
    @(negedge clk);
    chk_cnt++; if ({busy, out_valid, req_ready} !== 6'b110000) $display("FAIL rm_full: got busy=%b ov=%b rr=%b required 1/1/0000", busy, out_valid, req_ready); else pass_cnt++;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_cnt++; if ({busy, out_valid, req_ready} !== 6'b0) $display("FAIL rm_async: got busy=%b ov=%b rr=%b required 0/0/0000", busy, out_valid, req_ready); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 req_valid = '0; rst_n = 1'b1; out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk_cnt++; if ({out_valid, busy} !== 2'b00) $display("FAIL rm_stale_%0d: got ov=%b busy=%b required 0/0", s, out_valid, busy); else pass_cnt++;
      next_cycle();
    end
    req_valid = 4'b1001;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL rm_first_grant: got %b required 0001", req_ready); else pass_cnt++;
    next_cycle(); req_valid = '0;
    repeat (3) next_cycle();
  endtask

  task automatic test_sparse();
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL sparse_idle_%0d: got %b required 0000", s, req_ready); else pass_cnt++;
      next_cycle();
    end
    req_valid = 4'b1001; randomize_data();
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL sparse_first: got %b required 1000", req_ready); else pass_cnt++;
    next_cycle(); req_valid = 4'b0001;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL sparse_second: got %b required 0001", req_ready); else pass_cnt++;
    next_cycle(); req_valid = '0;
    @(negedge clk);
    chk_cnt++; if ({out_valid, out_id} !== {1'b1, 2'd3}) $display("FAIL sparse_out3: got v=%b id=%0d required 1/3", out_valid, out_id); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    chk_cnt++; if ({out_valid, out_id} !== {1'b1, 2'd0}) $display("FAIL sparse_out0: got v=%b id=%0d required 1/0", out_valid, out_id); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0 || exp_q.size() != 0) $display("FAIL sparse_empty: got ov=%b pending=%0d required 0/0", out_valid, exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    apply_reset();
    test_round_robin();
    test_backpressure();
    test_special();
    test_reset_mid();
    test_sparse();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
